// File: rtl/morse_pkg.sv
// Shared widths, slot-word layout and FSM state encoding for the Morse
// transmit sequencer.
package morse_pkg;

  localparam int SLOT_COUNT = 12;
  localparam int PAT_W      = 22;
  localparam int LEN_W      = 5;
  localparam int DATA_W     = 27;
  localparam int MAX_LEN    = 22;
  localparam int ADDR_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    GAP,
    DONE
  } state_t;

  function automatic logic [LEN_W-1:0] word_len(input logic [DATA_W-1:0] w);
    return w[DATA_W-1 -: LEN_W];
  endfunction

  function automatic logic [PAT_W-1:0] word_pat(input logic [DATA_W-1:0] w);
    return w[PAT_W-1:0];
  endfunction

  // Lengths above the pattern width would shift out zeros; cap them.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : l;
  endfunction

endpackage

// File: rtl/morse_tx_sequencer_tick.sv
// Morse unit prescaler: down-counter that pulses tick_o once every TICK_DIV
// cycles; restart_i reloads it so the next unit starts a full period later.
module morse_unit_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart_i,
  output logic tick_o,
  output logic near_o
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (restart_i || (cnt_q == '0)) begin
      cnt_d = CW'(TICK_DIV - 1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);
  // One cycle before the tick; lets GAP hand over early so LOAD fits in the gap.
  assign near_o = (cnt_q == CW'(1));

endmodule

// File: rtl/morse_tx_sequencer.sv
// Morse sequencer: writes encoded characters into the 12-slot store, then
// replays them as unit-timed key_out with inter-character gaps.
//
// state | meaning
// IDLE  | accept characters, wait for start
// LOAD  | rd_addr presents slot, word latched at the next edge
// SEND  | shift pattern out, one bit per unit
// GAP   | key low between characters (LOAD completes the last cycle)
// DONE  | end of message, done pulses on exit
module morse_tx_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_DIV  = 4,
  parameter int GAP_UNITS = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] char_data,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic              start,
  input  logic              clear,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              key_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count,
  output logic              full
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [PAT_W-1:0]  shift_q, shift_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  bit_q, bit_d;
  logic              full_q, wr_en_q, key_q, busy_q, done_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              restart, tick, near, last, xfer;

  morse_unit_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK       (CLK),
    .RST       (RST),
    .restart_i (restart),
    .tick_o    (tick),
    .near_o    (near)
  );

  assign char_ready = !RST && (state_q == IDLE) && !full_q && !start && !clear;
  assign xfer       = char_valid && char_ready;
  assign last       = (rd_addr_q == count_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_addr_d = rd_addr_q;
    shift_d   = shift_q;
    len_d     = len_q;
    bit_d     = bit_q;
    restart   = 1'b0;
    if (xfer) begin
      count_d = count_q + ADDR_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (start && (count_q != '0)) begin
          state_d   = LOAD;
          rd_addr_d = ADDR_W'(1);
        end
      end
      LOAD: begin
        shift_d = word_pat(rd_data);
        len_d   = clamp_len(word_len(rd_data));
        bit_d   = '0;
        restart = 1'b1;
        if (len_d == '0) begin
          state_d = last ? DONE : GAP;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + LEN_W'(1);
          if (bit_d == len_q) begin
            state_d = last ? DONE : GAP;
            bit_d   = '0;
            restart = 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          bit_d = bit_q + LEN_W'(1);
        end
        if (near && (bit_q == LEN_W'(GAP_UNITS - 1))) begin
          state_d   = LOAD;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DONE: begin
        state_d   = IDLE;
        rd_addr_d = '0;
      end
      default: begin
        state_d   = IDLE;
        rd_addr_d = '0;
      end
    endcase
    if (clear) begin
      state_d   = IDLE;
      count_d   = '0;
      rd_addr_d = '0;
      bit_d     = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rd_addr_q <= '0;
      shift_q   <= '0;
      len_q     <= '0;
      bit_q     <= '0;
      full_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      key_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      shift_q   <= shift_d;
      len_q     <= len_d;
      bit_q     <= bit_d;
      full_q    <= (count_d == ADDR_W'(SLOT_COUNT));
      wr_en_q   <= xfer;
      if (xfer) begin
        wr_addr_q <= count_q + ADDR_W'(1);
        wr_data_q <= char_data;
      end
      // key_out trails the state by one cycle, giving the two-edge start latency.
      key_q     <= (state_q == SEND) && shift_q[0] && !clear;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_q == DONE) && !clear;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = rd_addr_q;
  assign key_out = key_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign count   = count_q;
  assign full    = full_q;

endmodule

// File: doc/morse_tx_sequencer.md
Name: morse_tx_sequencer

Overview:
Controller for the 12-slot Morse character store; 27-bit slot word = {len[4:0], pattern[21:0]}.
- Accepts encoded characters from the encoder side over a valid/ready handshake and writes them to slots 1..12 in arrival order.
- On start, reads the slots back in order and serialises each pattern onto key_out at Morse unit timing, with an inter-character gap.
- Sits between the character encoder and the transmitter output stage; owns all write/read addressing and timing.

Parameters:
TICK_DIV, 4, CLK cycles per Morse unit (>=2); each pattern bit is held exactly TICK_DIV cycles.
GAP_UNITS, 3, units of key_out low inserted between consecutive characters (>=1).

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  reset, asynchronous, active-high
char_data  input  27  {len, pattern} from encoder; bit 0 of pattern is sent first
char_valid  input  1  char_data valid
char_ready  output  1  sequencer accepts char_data this cycle
start  input  1  begin transmission of stored message (level sampled in IDLE)
clear  input  1  discard stored message / abort transmission
wr_en  output  1  slot write strobe to store
wr_addr  output  4  slot address 1..12
wr_data  output  27  word to write
rd_addr  output  4  slot read address 1..12; 0 when idle
rd_data  input  27  store word at rd_addr, combinational
key_out  output  1  serial Morse key (1 = tone)
busy  output  1  transmission in progress
done  output  1  one-cycle pulse at end of message
count  output  4  number of stored characters 0..12
full  output  1  count == 12

Behaviour:
- RST (async): state IDLE. All outputs 0: char_ready, wr_en, wr_addr, wr_data, rd_addr, key_out, busy, done, count, full. Shift, bit and tick counters 0.
- All outputs are driven from registers; there is no input-to-output combinational path except char_ready.
- States:
  - IDLE: start && count>0 -> LOAD with slot=1. start with count==0 is ignored.
  - LOAD: one cycle; rd_addr=slot. At the next edge, latch rd_data.pattern into the shift register and len=min(rd_data.len,22). len==0 -> GAP (or DONE if last slot); otherwise -> SEND.
  - SEND: key_out=shift[0]. Every TICK_DIV cycles shift right and bit++. After len bits: last slot -> DONE, else -> GAP.
  - GAP: key_out=0 for GAP_UNITS*TICK_DIV cycles, then slot++ -> LOAD.
  - DONE: done=1 for one cycle, busy=0 on exit -> IDLE. count is retained, so start replays the message.
- busy=1 in LOAD/SEND/GAP/DONE.
- Latency: start sampled at edge k; the first bit appears on key_out after edge k+2.
- The tick counter is reset on every entry to SEND/GAP, so each unit lasts exactly TICK_DIV cycles.
- Write handshake: char_ready = (state==IDLE) && !full && !start && !clear.
  - Transfer occurs when char_valid && char_ready at an edge.
  - Next cycle: wr_en=1 for one cycle, wr_addr=count_old+1, wr_data=char_data. count increments at the same edge as the transfer.
- full: further characters stall (char_ready=0); no overwrite, no wrap.
- clear in any state: within one edge -> IDLE, count=0, key_out=0, busy=0, no done pulse, pending wr_en suppressed. Store contents are left untouched.
- Simultaneous events in IDLE: clear > start > char_valid.
- start while busy is ignored. char_valid while busy stalls.

Decomposition:
- Package morse_pkg holds:
  - SLOT_COUNT=12, PAT_W=22, LEN_W=5, DATA_W=27, MAX_LEN=22.
  - State enum {IDLE, LOAD, SEND, GAP, DONE}.
  - Field-extract helpers for len and pattern.
- One sub-module, morse_unit_tick: prescaler with sync restart input; outputs a tick pulse every TICK_DIV cycles.

Test Plan:
1. Reset: RST pulse mid-SEND -> all outputs 0 immediately (asynchronously), count=0.
2. Write handshake:
   - Push 12 chars back-to-back -> wr_addr 1..12 each with a single wr_en, count=12, full=1.
   - 13th char_valid -> char_ready=0, count stays 12.
3. Two-character message, TICK_DIV=4, GAP_UNITS=3, slot1={1,'b1}, slot2={3,'b111}; start -> key_out sequence:
   - 4 cycles high, 12 cycles low, 12 cycles high.
   - Then done pulse with busy=0; key_out first high 2 cycles after start.
4. Length edge cases:
   - len=0 slot -> gap only, no high bits.
   - len=31 -> clamped to 22 bits; a pattern with alternating bits yields 22 units.
5. Clear mid-GAP -> key_out=0, busy=0 next cycle, no done pulse, count=0; a following start is ignored.
6. Simultaneous events in IDLE:
   - start and char_valid together -> start wins, no write.
   - clear and start together -> clear wins, busy stays 0.
   - Replay after done -> identical key_out trace.
